uart_cmd_reset_gen: RTL and testbench
=====================================

// Module: uart_cmd_reset_gen
// PURPOSE
//   Parametrised UART-command reset generator for the logic analyser.
//   - Watches the byte stream from the UART receiver for a SEQ_LEN-byte prefix of CMD_BYTE.
//   - The prefix is followed by one channel-mask byte.
//   - Issues a PULSE_CYCLES-wide reset on each selected rst_out channel.
//   - Resynchronises rx_data_fresh into clk and drops incomplete sequences after an inter-byte timeout.
// PARAMETERS
//   CMD_BYTE        8'hFF   prefix byte value
//   SEQ_LEN         3       prefix bytes required (>=1)
//   NUM_CH          4       reset output channels (1..8)
//   PULSE_CYCLES    16      rst_out high time in clk cycles (>=1)
//   TIMEOUT_CYCLES  50000   max clk cycles between bytes of one sequence (>=2)
//   SYNC_STAGES     2       synchroniser flops on rx_data_fresh (>=2)
// PORTS
//   clk            in   1       system clock; the only clock
//   rst            in   1       synchronous, active-high reset
//   rx_data_fresh  in   1       UART byte-valid level/strobe, asynchronous to clk
//   rx_data        in   8       received byte; stable from fresh rise for >= SYNC_STAGES+2 clk
//   rst_out        out  NUM_CH  per-channel reset pulses
//   busy           out  1       high while a sequence is in progress or a pulse is active
//   cmd_err        out  1       1-cycle pulse: mask byte was zero, or timeout occurred
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0. Applies mid-pulse: rst_out drops the next cycle.
//   Byte accept: byte_stb = rising edge of the synchronised fresh signal.
//     - Detected SYNC_STAGES+1 clk after the fresh rise.
//     - rx_data is captured on the byte_stb cycle.
//   States:
//     IDLE:   on byte_stb with byte==CMD_BYTE: cnt<=1; go to SELECT if SEQ_LEN==1, else MATCH.
//             Any other byte is ignored.
//     MATCH:  on byte_stb with byte==CMD_BYTE: cnt++; cnt reaching SEQ_LEN -> SELECT.
//             On byte_stb with any other byte: cnt<=0 -> IDLE, no cmd_err.
//     SELECT: the next byte_stb is the mask; any value is accepted, including CMD_BYTE.
//             mask[NUM_CH-1:0]!=0: latch mask -> PULSE.
//             mask==0: cmd_err pulse -> IDLE.
//             Mask bits >= NUM_CH are ignored.
//     PULSE:  rst_out = latched mask for exactly PULSE_CYCLES cycles, starting the cycle after mask
//             accept; then -> IDLE.
//             byte_stb during PULSE is dropped (no re-trigger, no extension).
//   Timeout:
//     - Idle counter clears on every byte_stb; it counts only in MATCH and SELECT.
//     - Reaching TIMEOUT_CYCLES -> IDLE, cnt<=0, cmd_err pulse.
//     - Timeout and byte_stb in the same cycle: the byte wins and the counter clears.
//   busy = (state != IDLE). cmd_err is never high for two consecutive cycles.
//   Widths:
//     - cnt is $clog2(SEQ_LEN+1) bits.
//     - Pulse counter is $clog2(PULSE_CYCLES+1) bits.
//     - Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
//     - No counter wraps; each saturates at or is cleared by its terminal value.
//   Total latency: fresh rise of the mask byte -> rst_out high is SYNC_STAGES+2 clk.
// STRUCTURE
//   Shared package la_uart_pkg: state encoding (IDLE/MATCH/SELECT/PULSE, 2 bits) and the default
//   CMD_BYTE constant. The existing UART blocks use the same package.
//   Sub-module sync_edge_det (SYNC_STAGES flop synchroniser + rising-edge detect -> byte_stb).
//   Top: FSM, prefix counter, timeout counter, pulse counter, mask register.
// TESTING
//   1. Defaults; send FF,FF,FF,05 with 20 clk between bytes
//      -> rst_out=4'b0101 for exactly 16 cycles, starting SYNC_STAGES+2 clk after the 05 fresh rise;
//         busy high from the first FF until pulse end.
//   2. Send FF,FF,3C,FF,FF,FF,01
//      -> 3C returns to IDLE silently; one pulse on rst_out[0] only; cmd_err never asserted.
//   3. Send FF,FF,FF,00 -> cmd_err single-cycle pulse; rst_out stays 0; busy low afterwards.
//   4. Send FF,FF, then wait 50000 clk -> cmd_err pulse, busy low.
//      A following FF,FF,FF,08 -> rst_out[3] pulse.
//   5. Send FF,FF,FF,0F, and a byte FF during the pulse -> pulse width is still 16 cycles.
//      Assert rst on pulse cycle 5 -> rst_out=0 on the next cycle; state IDLE.
//   6. SEQ_LEN=1, NUM_CH=2: send FF,FE -> rst_out=2'b10 (bits above NUM_CH ignored).
//      rx_data_fresh toggled asynchronously -> no double byte_stb per fresh rise.

Source files
------------

// File: rtl/la_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_uart_pkg
//  Description : Shared logic-analyser UART definitions (FSM encoding, default command byte)
//  Revision    : 1.0  initial release
// ============================================================================
package la_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MATCH  = 2'd1,
        ST_SELECT = 2'd2,
        ST_PULSE  = 2'd3
    } la_state_t;

    localparam logic [7:0] c_cmd_byte_default = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchroniser followed by a registered rising-edge strobe
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic stb
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_stb;

    // The strobe is registered so it lands SYNC_STAGES+1 clocks after the input rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_stb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_stb  <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_reset_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_reset_gen
//  Description : Decodes a CMD_BYTE prefix plus channel mask from the UART byte
//                stream and drives PULSE_CYCLES-wide resets on the selected channels
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_reset_gen
    import la_uart_pkg::*;
#(
    parameter logic [7:0] CMD_BYTE       = c_cmd_byte_default,
    parameter int         SEQ_LEN        = 3,
    parameter int         NUM_CH         = 4,
    parameter int         PULSE_CYCLES   = 16,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data_fresh,
    input  logic [7:0]        rx_data,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              cmd_err
);

    localparam int c_cnt_w  = $clog2(SEQ_LEN + 1);
    localparam int c_pcnt_w = $clog2(PULSE_CYCLES + 1);
    localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_one   = 1;
    localparam logic [c_cnt_w-1:0]  c_seq_last  = c_cnt_w'(SEQ_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_seq_full  = c_cnt_w'(SEQ_LEN);
    localparam logic [c_pcnt_w-1:0] c_pcnt_one  = 1;
    localparam logic [c_pcnt_w-1:0] c_pulse_end = c_pcnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_one  = 1;
    localparam logic [c_tcnt_w-1:0] c_timeout   = c_tcnt_w'(TIMEOUT_CYCLES);

    logic                w_byte_stb;
    logic [NUM_CH-1:0]   w_mask_in;
    logic [c_tcnt_w-1:0] w_tcnt_inc;

    la_state_t           r_state,   w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt,     w_cnt_nxt;
    logic [c_tcnt_w-1:0] r_tcnt,    w_tcnt_nxt;
    logic [c_pcnt_w-1:0] r_pcnt,    w_pcnt_nxt;
    logic [NUM_CH-1:0]   r_mask,    w_mask_nxt;
    logic                r_cmd_err, w_cmd_err_nxt;
    logic [NUM_CH-1:0]   r_rst_out;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_data_fresh),
        .stb      (w_byte_stb)
    );

    assign w_mask_in  = rx_data[NUM_CH-1:0];
    assign w_tcnt_inc = r_tcnt + c_tcnt_one;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tcnt_nxt    = r_tcnt;
        w_pcnt_nxt    = r_pcnt;
        w_mask_nxt    = r_mask;
        w_cmd_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tcnt_nxt = '0;
                if (w_byte_stb && (rx_data == CMD_BYTE)) begin
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = (SEQ_LEN == 1) ? ST_SELECT : ST_MATCH;
                end
            end
            ST_MATCH: begin
                if (w_byte_stb) begin
                    w_tcnt_nxt = '0;
                    if (rx_data == CMD_BYTE) begin
                        if (r_cnt == c_seq_last) begin
                            w_cnt_nxt   = c_seq_full;
                            w_state_nxt = ST_SELECT;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_tcnt_inc == c_timeout) begin
                    w_cnt_nxt     = '0;
                    w_tcnt_nxt    = '0;
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                end
            end
            ST_SELECT: begin
                // Any byte here is the mask, even one equal to CMD_BYTE.
                if (w_byte_stb) begin
                    w_tcnt_nxt = '0;
                    w_cnt_nxt  = '0;
                    if (w_mask_in != '0) begin
                        w_mask_nxt  = w_mask_in;
                        w_pcnt_nxt  = '0;
                        w_state_nxt = ST_PULSE;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end else if (w_tcnt_inc == c_timeout) begin
                    w_cnt_nxt     = '0;
                    w_tcnt_nxt    = '0;
                    w_cmd_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                end
            end
            ST_PULSE: begin
                w_tcnt_nxt = '0;
                if (r_pcnt == c_pulse_end) begin
                    w_pcnt_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pcnt_nxt = r_pcnt + c_pcnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // rst_out is a flop so the reset lines never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_pcnt    <= '0;
            r_mask    <= '0;
            r_cmd_err <= 1'b0;
            r_rst_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_mask    <= w_mask_nxt;
            r_cmd_err <= w_cmd_err_nxt;
            r_rst_out <= (w_state_nxt == ST_PULSE) ? w_mask_nxt : '0;
        end
    end

    assign rst_out = r_rst_out;
    assign busy    = (r_state != ST_IDLE);
    assign cmd_err = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_reset_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_reset_gen
//  Description : Bench for uart_cmd_reset_gen with a byte-level reference model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_reset_gen;

    localparam int N = 70000;

    typedef struct {
        int         inst;
        int         t;
        bit         is_rst;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, fresh_a, fresh_b;
    logic [7:0] data_a, data_b;
    logic [3:0] rst_out_a;
    logic [1:0] rst_out_b;
    logic       busy_a, busy_b, err_a, err_b;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        evq[$];
    logic [9:0] obs_a [N];
    logic [9:0] obs_b [N];
    logic [9:0] expv  [N];

    always #5 clk = ~clk;

    uart_cmd_reset_gen u_dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .rx_data_fresh (fresh_a),
        .rx_data       (data_a),
        .rst_out       (rst_out_a),
        .busy          (busy_a),
        .cmd_err       (err_a)
    );

    uart_cmd_reset_gen #(
        .SEQ_LEN        (1),
        .NUM_CH         (2),
        .PULSE_CYCLES   (5),
        .TIMEOUT_CYCLES (200)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .rx_data_fresh (fresh_b),
        .rx_data       (data_b),
        .rst_out       (rst_out_b),
        .busy          (busy_b),
        .cmd_err       (err_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < N) begin
            obs_a[cyc] <= {4'b0, rst_out_a, busy_a, err_a};
            obs_b[cyc] <= {6'b0, rst_out_b, busy_b, err_b};
        end
    end

    // Fresh rises mid-period; the byte is seen by the FSM in period rise+3.
    task automatic send(input int inst, input logic [7:0] b, input int hold, input int gap);
        ev_t e;
        int  d;
        @(posedge clk);
        d = $urandom_range(1, 9);
        #(d);
        if (inst == 0) begin data_a = b; fresh_a = 1'b1; end
        else           begin data_b = b; fresh_b = 1'b1; end
        e.inst = inst; e.t = cyc + 3; e.is_rst = 1'b0; e.b = b;
        evq.push_back(e);
        repeat (hold) @(posedge clk);
        d = $urandom_range(1, 9);
        #(d);
        if (inst == 0) begin fresh_a = 1'b0; data_a = 8'($urandom); end
        else           begin fresh_b = 1'b0; data_b = 8'($urandom); end
        repeat (gap) @(posedge clk);
    endtask

    task automatic log_reset(input int inst, input int t);
        ev_t e;
        e.inst = inst; e.t = t; e.is_rst = 1'b1; e.b = 8'h00;
        evq.push_back(e);
    endtask

    task automatic fill_busy(input int a, input int b);
        for (int c = a; c <= b; c++)
            if (c >= 0 && c < N) expv[c][1] = 1'b1;
    endtask

    // Expected {rst_out, busy, cmd_err} per clock period from the byte-level rules.
    task automatic run_model(input int inst, input int endc);
        int         seq, nch, p, tmo, t, cnt, last, bstart, pend;
        bit         await_m;
        logic [7:0] nmask, m, b;
        if (inst == 0) begin seq = 3; nch = 4; p = 16; tmo = 50000; end
        else           begin seq = 1; nch = 2; p = 5;  tmo = 200;   end
        nmask = 8'((1 << nch) - 1);
        for (int c = 0; c < N; c++) expv[c] = '0;
        cnt = 0; await_m = 1'b0; last = 0; bstart = 0; pend = 0;
        foreach (evq[i]) begin
            if (evq[i].inst != inst) continue;
            t = evq[i].t;
            b = evq[i].b;
            if ((cnt > 0 || await_m) && (t - last > tmo)) begin
                if (last + tmo + 1 < N) expv[last + tmo + 1][0] = 1'b1;
                fill_busy(bstart, last + tmo);
                cnt = 0; await_m = 1'b0;
            end
            if (evq[i].is_rst) begin
                if (cnt > 0 || await_m) fill_busy(bstart, t);
                for (int c = t + 1; c < N; c++) expv[c] = '0;
                cnt = 0; await_m = 1'b0; pend = 0;
                continue;
            end
            if (t < pend) continue;
            if (await_m) begin
                m = b & nmask;
                if (m != 8'h00) begin
                    for (int c = t + 1; c <= t + p; c++)
                        if (c < N) expv[c][9:2] = m;
                    fill_busy(bstart, t + p);
                    pend = t + 1 + p;
                end else begin
                    if (t + 1 < N) expv[t + 1][0] = 1'b1;
                    fill_busy(bstart, t);
                end
                await_m = 1'b0; cnt = 0;
            end else if (cnt > 0) begin
                if (b == 8'hFF) begin
                    cnt++;
                    if (cnt == seq) await_m = 1'b1;
                end else begin
                    fill_busy(bstart, t);
                    cnt = 0;
                end
            end else if (b == 8'hFF) begin
                cnt = 1; bstart = t + 1;
                if (seq == 1) await_m = 1'b1;
            end
            last = t;
        end
        if (cnt > 0 || await_m) begin
            if (endc - last > tmo) begin
                if (last + tmo + 1 < N) expv[last + tmo + 1][0] = 1'b1;
                fill_busy(bstart, last + tmo);
            end else begin
                fill_busy(bstart, endc);
            end
        end
    endtask

    task automatic compare(input int inst, input int endc);
        logic [9:0] o;
        for (int c = 1; c <= endc; c++) begin
            o = (inst == 0) ? obs_a[c] : obs_b[c];
            checks++;
            assert (o === expv[c]) else begin
                failures++;
                $error("FAIL cycle_dut%0d period=%0d observed{rst,busy,err}=%h expected=%h",
                       inst, c, o, expv[c]);
            end
        end
    endtask

    initial begin
        int r0, q, endc;
        logic [7:0] b;
        rst_a = 1'b1; rst_b = 1'b1;
        fresh_a = 1'b0; fresh_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        log_reset(0, 0);
        log_reset(1, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        checks++; assert (rst_out_a === 4'b0) else begin failures++; $error("FAIL reset_rst_a observed=%b expected=0", rst_out_a); end
        checks++; assert (busy_a === 1'b0)    else begin failures++; $error("FAIL reset_busy_a observed=%b expected=0", busy_a); end
        checks++; assert (err_a === 1'b0)     else begin failures++; $error("FAIL reset_err_a observed=%b expected=0", err_a); end
        checks++; assert (rst_out_b === 2'b0) else begin failures++; $error("FAIL reset_rst_b observed=%b expected=0", rst_out_b); end
        checks++; assert (busy_b === 1'b0)    else begin failures++; $error("FAIL reset_busy_b observed=%b expected=0", busy_b); end
        checks++; assert (err_b === 1'b0)     else begin failures++; $error("FAIL reset_err_b observed=%b expected=0", err_b); end

        // Basic command, 20 clk per byte.
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'h05, 5, 15);
        repeat (30) @(posedge clk);
        // Broken prefix then a good command.
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'h3C, 5, 15);
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'h01, 5, 15);
        repeat (30) @(posedge clk);
        // Zero mask.
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'h00, 5, 15);
        repeat (30) @(posedge clk);
        // Inter-byte timeout, then recovery.
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15);
        repeat (50010) @(posedge clk);
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'h08, 5, 15);
        repeat (30) @(posedge clk);
        // Byte during pulse is dropped.
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15);
        send(0, 8'h0F, 6, 4); send(0, 8'hFF, 6, 6);
        repeat (40) @(posedge clk);
        // Reset on the fifth pulse cycle.
        send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15); send(0, 8'hFF, 5, 15);
        send(0, 8'h0F, 5, 0);
        r0 = evq[$].t - 3;
        while (cyc < r0 + 8) begin @(posedge clk); #1; end
        rst_a = 1'b1;
        q = cyc;
        log_reset(0, q);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        checks++; assert (rst_out_a === 4'b0) else begin failures++; $error("FAIL midpulse_rst observed=%b expected=0", rst_out_a); end
        checks++; assert (busy_a === 1'b0)    else begin failures++; $error("FAIL midpulse_busy observed=%b expected=0", busy_a); end
        repeat (30) @(posedge clk);
        // Random traffic on the default instance.
        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 9) < 6) ? 8'hFF : 8'($urandom);
            send(0, b, $urandom_range(5, 8), $urandom_range(2, 12));
        end
        repeat (60) @(posedge clk);

        // Single-byte prefix, two channels: upper mask bits ignored.
        send(1, 8'hFF, 5, 10); send(1, 8'hFE, 5, 10);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 150; i++) begin
            b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            send(1, b, $urandom_range(5, 8),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(200, 260) : $urandom_range(2, 12));
        end
        repeat (300) @(posedge clk);

        @(negedge clk);
        @(negedge clk);
        endc = cyc - 1;
        if (endc >= N) endc = N - 1;
        run_model(0, endc);
        compare(0, endc);
        run_model(1, endc);
        compare(1, endc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
